// File: rtl/ext_bus_responder_pkg.sv
// Shared definitions for the external bus responder: FSM state encoding,
// default window base and bus strobe polarity.
package ext_bus_responder_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_WAIT,
      ST_RD_DRIVE,
      ST_WR_CAPT,
      ST_ERR
   } state_t;

   localparam logic [15:0] DEFAULT_BASE  = 16'hC000;
   localparam logic        STROBE_ACTIVE = 1'b0;
   localparam logic        STROBE_IDLE   = 1'b1;

endpackage

// File: rtl/ext_bus_responder_if.sv
// Address/strobe/status bundle between the core-side master and the responder.
// The bidirectional data bus stays a plain inout port on the responder.
interface ext_bus_responder_if;

   logic [15:0] A;
   logic        nRD;
   logic        nWR;
   logic        Hit;
   logic        Conflict;
   logic [7:0]  WrCount;

   modport master (output A, nRD, nWR, input Hit, Conflict, WrCount);
   modport slave  (input A, nRD, nWR, output Hit, Conflict, WrCount);

endinterface

// File: rtl/ext_bus_responder_ram.sv
// Backing store for the response window: synchronous write, asynchronous read.
module ext_bus_responder_ram #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [7:0]        wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [7:0]        rdata
);

   logic [7:0] mem [2**ADDR_W];

   // NOTE: the array has no reset on purpose; contents survive RESET.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/ext_bus_responder.sv
// Off-chip responder for core-initiated SM83 bus cycles: answers reads and
// writes inside a RAM-backed address window and flags protocol violations.
module ext_bus_responder
   import ext_bus_responder_pkg::*;
#(
   parameter logic [15:0] BASE      = DEFAULT_BASE,
   parameter int          SIZE_LOG2 = 8,
   parameter int          READ_LAT  = 1
) (
   input  logic                  CLK,
   input  logic                  RESET,
   ext_bus_responder_if.slave    bus,
   inout  wire  [7:0]            DataBus
);

   state_t               state, state_n;
   logic [1:0]           lat_cnt, lat_cnt_n;
   logic [7:0]           cap_data;
   logic [SIZE_LOG2-1:0] cap_addr;
   logic                 hit_q;
   logic                 conflict_q;
   logic [7:0]           wr_count;
   logic                 cap_load;
   logic                 commit;
   logic                 set_conflict;
   logic [16:0]          offset;
   logic                 in_win;
   logic [SIZE_LOG2-1:0] index;
   logic [7:0]           rd_data;
   logic                 rd_act, wr_act;
   logic                 drive;

   // 17-bit subtraction: addresses below BASE land far above the window.
   assign offset = {1'b0, bus.A} - {1'b0, BASE};
   assign in_win = offset < (17'd1 << SIZE_LOG2);
   assign index  = offset[SIZE_LOG2-1:0];
   assign rd_act = (bus.nRD == STROBE_ACTIVE);
   assign wr_act = (bus.nWR == STROBE_ACTIVE);

   // NOTE: every output of this block gets a default first, so no path leaves
   // one unassigned and no latch is inferred.
   always_comb begin
      state_n      = state;
      lat_cnt_n    = lat_cnt;
      cap_load     = 1'b0;
      commit       = 1'b0;
      set_conflict = 1'b0;
      if (rd_act && wr_act && in_win) begin
         state_n      = ST_ERR;
         set_conflict = 1'b1;
      end else begin
         case (state)
            ST_IDLE: begin
               if (rd_act && in_win) begin
                  if (READ_LAT == 0) begin
                     state_n = ST_RD_DRIVE;
                  end else begin
                     state_n   = ST_RD_WAIT;
                     lat_cnt_n = 2'(READ_LAT);
                  end
               end else if (wr_act && in_win) begin
                  state_n  = ST_WR_CAPT;
                  cap_load = 1'b1;
               end
            end
            ST_RD_WAIT: begin
               if (!rd_act)              state_n = ST_IDLE;
               else if (lat_cnt <= 2'd1) state_n = ST_RD_DRIVE;
               else                      lat_cnt_n = lat_cnt - 2'd1;
            end
            ST_RD_DRIVE: begin
               // Address slipping out of the window mid-drive is a protocol error.
               if (!rd_act) begin
                  state_n = ST_IDLE;
               end else if (!in_win) begin
                  state_n      = ST_IDLE;
                  set_conflict = 1'b1;
               end
            end
            ST_WR_CAPT: begin
               if (!wr_act) begin
                  commit  = 1'b1;
                  state_n = ST_IDLE;
               end else if (in_win) begin
                  cap_load = 1'b1;
               end else begin
                  state_n = ST_IDLE;
               end
            end
            ST_ERR: begin
               if (!rd_act && !wr_act) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of its peers.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state      <= ST_IDLE;
         lat_cnt    <= '0;
         hit_q      <= 1'b0;
         conflict_q <= 1'b0;
         wr_count   <= '0;
         cap_data   <= '0;
         cap_addr   <= '0;
      end else begin
         state   <= state_n;
         lat_cnt <= lat_cnt_n;
         hit_q   <= in_win;
         if (set_conflict) conflict_q <= 1'b1;
         if (commit)       wr_count   <= wr_count + 8'd1;
         if (cap_load) begin
            cap_data <= DataBus;
            cap_addr <= index;
         end
      end
   end

   ext_bus_responder_ram #(.ADDR_W(SIZE_LOG2)) u_ram (
      .clk   (CLK),
      .we    (commit),
      .waddr (cap_addr),
      .wdata (cap_data),
      .raddr (index),
      .rdata (rd_data)
   );

   // Gated by CLK so the core's precharge phase is never contested.
   assign drive   = (state == ST_RD_DRIVE) && CLK && rd_act;
   assign DataBus = drive ? rd_data : 8'bz;

   assign bus.Hit      = hit_q;
   assign bus.Conflict = conflict_q;
   assign bus.WrCount  = wr_count;

endmodule
